// File: rtl/fc_seq_pkg.sv
// rtl/fc_seq_pkg.sv - shared types and constants for the FC layer sequencer
package fc_seq_pkg;

  localparam int DEF_ARRAY_DIM = 16;
  localparam int DEF_MAX_TILES = 15;

  localparam int NODE_W = 7;
  localparam int TILE_W = 4;
  localparam int LEN_W  = 9;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_W    = 3'd1,
    S_FEED      = 3'd2,
    S_DRAIN     = 3'd3,
    S_WAIT_LAST = 3'd4,
    S_DONE      = 3'd5
  } fc_state_e;

endpackage

// File: rtl/fc_beat_counter.sv
// rtl/fc_beat_counter.sv - clearable beat counter with terminal-count detect
module fc_beat_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_inc,
  input  logic [W-1:0] i_term,
  output logic         o_hit
);

  logic [W-1:0] r_count;
  logic         w_at_term;
  logic         w_next_term;

  assign w_at_term   = (r_count == i_term);
  // Hit includes the beat arriving this cycle so the tile can close without a bubble.
  assign w_next_term = i_inc && (({1'b0, r_count} + {{W{1'b0}}, 1'b1}) == {1'b0, i_term});
  assign o_hit       = w_at_term || w_next_term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && !w_at_term) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fc_layer_sequencer.sv
// rtl/fc_layer_sequencer.sv - tiles one FC layer into weight-fetch and input-feed commands
module fc_layer_sequencer
  import fc_seq_pkg::*;
#(
  parameter int ARRAY_DIM = DEF_ARRAY_DIM,
  parameter int MAX_TILES = DEF_MAX_TILES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  in_len_i,
  input  logic [NODE_W-1:0] out_node_num_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              wfetch_valid_o,
  input  logic              wfetch_ready_i,
  output logic [TILE_W-1:0] wfetch_tile_o,
  output logic              feed_valid_o,
  input  logic              feed_ready_i,
  output logic [TILE_W-1:0] feed_tile_o,
  output logic [NODE_W-1:0] feed_len_o,
  input  logic              pvalid_i,
  input  logic              acc_last_i,
  output logic [NODE_W-1:0] out_node_num_o,
  output logic [TILE_W-1:0] tile_num_o
);

  localparam int SHIFT = $clog2(ARRAY_DIM);

  fc_state_e         r_state;
  logic [NODE_W-1:0] r_nodes;
  logic [TILE_W-1:0] r_tiles;
  logic [TILE_W-1:0] r_tile;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_wfetch_valid;
  logic              r_feed_valid;

  logic [LEN_W:0]    w_tiles_full;
  logic              w_cfg_bad;
  logic              w_proto_err;
  logic              w_beat_inc;
  logic              w_beat_hit;
  logic              w_beat_clear;
  logic              w_last_tile;
  logic              w_feed_xfer;
  logic              w_tile_done;

  assign w_tiles_full = ({1'b0, in_len_i} + (LEN_W+1)'(ARRAY_DIM - 1)) >> SHIFT;
  assign w_cfg_bad    = (in_len_i == '0) || (out_node_num_i == '0) ||
                        (w_tiles_full > (LEN_W+1)'(MAX_TILES));

  assign w_proto_err  = (pvalid_i && (r_state == S_IDLE || r_state == S_LOAD_W ||
                                      r_state == S_WAIT_LAST || r_state == S_DONE)) ||
                        (acc_last_i && (r_state != S_WAIT_LAST));

  // Beats may arrive while the feed command is still being handed off.
  assign w_beat_inc   = pvalid_i && (r_state == S_FEED || r_state == S_DRAIN);
  assign w_feed_xfer  = (r_state == S_FEED) && feed_ready_i;
  assign w_tile_done  = (w_feed_xfer && w_beat_hit) || ((r_state == S_DRAIN) && w_beat_hit);
  assign w_beat_clear = w_tile_done || (r_state == S_IDLE);
  assign w_last_tile  = (r_tile == (r_tiles - TILE_W'(1)));

  fc_beat_counter #(
    .W (NODE_W)
  ) u_beat_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_beat_clear),
    .i_inc   (w_beat_inc),
    .i_term  (r_nodes),
    .o_hit   (w_beat_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_nodes        <= '0;
      r_tiles        <= '0;
      r_tile         <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_wfetch_valid <= 1'b0;
      r_feed_valid   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (w_cfg_bad) begin
              r_err <= 1'b1;
            end else begin
              r_err          <= 1'b0;
              r_nodes        <= out_node_num_i;
              r_tiles        <= w_tiles_full[TILE_W-1:0];
              r_tile         <= '0;
              r_busy         <= 1'b1;
              r_wfetch_valid <= 1'b1;
              r_state        <= S_LOAD_W;
            end
          end
        end

        S_LOAD_W: begin
          if (wfetch_ready_i) begin
            r_wfetch_valid <= 1'b0;
            r_feed_valid   <= 1'b1;
            r_state        <= S_FEED;
          end
        end

        S_FEED: begin
          if (feed_ready_i) begin
            r_feed_valid <= 1'b0;
            r_state      <= S_DRAIN;
          end
        end

        S_DRAIN: begin
        end

        S_WAIT_LAST: begin
          if (acc_last_i) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Tile completion overrides the FEED->DRAIN step when the last beat lands on the handshake.
      if (w_tile_done) begin
        if (w_last_tile) begin
          r_state <= S_WAIT_LAST;
        end else begin
          r_tile         <= r_tile + TILE_W'(1);
          r_wfetch_valid <= 1'b1;
          r_state        <= S_LOAD_W;
        end
      end

      if (w_proto_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign err_o          = r_err;
  assign wfetch_valid_o = r_wfetch_valid;
  assign wfetch_tile_o  = r_tile;
  assign feed_valid_o   = r_feed_valid;
  assign feed_tile_o    = r_tile;
  assign feed_len_o     = r_nodes;
  assign out_node_num_o = r_nodes;
  assign tile_num_o     = r_tiles;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb/tb_fc_layer_sequencer.sv - directed table-driven bench for fc_layer_sequencer
module tb_fc_layer_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic [8:0] in_len_i;
  logic [6:0] out_node_num_i;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
  logic       wfetch_valid_o;
  logic       wfetch_ready_i;
  logic [3:0] wfetch_tile_o;
  logic       feed_valid_o;
  logic       feed_ready_i;
  logic [3:0] feed_tile_o;
  logic [6:0] feed_len_o;
  logic       pvalid_i;
  logic       acc_last_i;
  logic [6:0] out_node_num_o;
  logic [3:0] tile_num_o;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [8:0] len;
    logic [6:0] nodes;
    logic [3:0] tiles;
    logic       bad;
  } vec_t;

  vec_t vecs [8];

  fc_layer_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .in_len_i       (in_len_i),
    .out_node_num_i (out_node_num_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .wfetch_valid_o (wfetch_valid_o),
    .wfetch_ready_i (wfetch_ready_i),
    .wfetch_tile_o  (wfetch_tile_o),
    .feed_valid_o   (feed_valid_o),
    .feed_ready_i   (feed_ready_i),
    .feed_tile_o    (feed_tile_o),
    .feed_len_o     (feed_len_o),
    .pvalid_i       (pvalid_i),
    .acc_last_i     (acc_last_i),
    .out_node_num_o (out_node_num_o),
    .tile_num_o     (tile_num_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_layer(input logic [8:0] len, input logic [6:0] nodes,
                           input logic [3:0] exp_tiles, input logic exp_bad);
    logic early;
    wfetch_ready_i = 1'b1;
    feed_ready_i   = 1'b1;
    start_i        = 1'b1;
    in_len_i       = len;
    out_node_num_i = nodes;
    step();
    start_i = 1'b0;
    if (exp_bad) begin
      check("bad_cfg", 32'({err_o, busy_o, wfetch_valid_o, feed_valid_o}), 32'(4'b1000));
      step();
      step();
      check("bad_cfg_idle", 32'({err_o, busy_o, wfetch_valid_o, feed_valid_o}), 32'(4'b1000));
      return;
    end
    check("start_state", 32'({busy_o, err_o, wfetch_valid_o, feed_valid_o}), 32'(4'b1010));
    check("acc_cfg", 32'({tile_num_o, out_node_num_o}), 32'({exp_tiles, nodes}));
    for (int t = 0; t < int'(exp_tiles); t++) begin
      check("fetch", 32'({wfetch_valid_o, feed_valid_o, wfetch_tile_o}), 32'({2'b10, 4'(t)}));
      step();
      check("feed", 32'({feed_valid_o, wfetch_valid_o, feed_tile_o, feed_len_o}),
            32'({2'b10, 4'(t), nodes}));
      step();
      early = 1'b0;
      for (int b = 0; b < int'(nodes); b++) begin
        if (wfetch_valid_o || feed_valid_o) early = 1'b1;
        pvalid_i = 1'b1;
        step();
      end
      pvalid_i = 1'b0;
      check("no_early_cmd", 32'(early), 32'(0));
    end
    check("wait_last", 32'({wfetch_valid_o, feed_valid_o, busy_o, err_o, done_o}), 32'(5'b00100));
    acc_last_i = 1'b1;
    step();
    acc_last_i = 1'b0;
    check("done_pulse", 32'({done_o, busy_o, err_o}), 32'(3'b100));
    step();
    check("done_clear", 32'({done_o, busy_o}), 32'(2'b00));
    check("cfg_held", 32'({tile_num_o, out_node_num_o}), 32'({exp_tiles, nodes}));
  endtask

  initial begin
    n_cmp          = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    start_i        = 1'b0;
    in_len_i       = '0;
    out_node_num_i = '0;
    wfetch_ready_i = 1'b1;
    feed_ready_i   = 1'b1;
    pvalid_i       = 1'b0;
    acc_last_i     = 1'b0;

    vecs[0] = '{len: 9'd16,  nodes: 7'd4,   tiles: 4'd1,  bad: 1'b0};
    vecs[1] = '{len: 9'd40,  nodes: 7'd10,  tiles: 4'd3,  bad: 1'b0};
    vecs[2] = '{len: 9'd1,   nodes: 7'd1,   tiles: 4'd1,  bad: 1'b0};
    vecs[3] = '{len: 9'd240, nodes: 7'd2,   tiles: 4'd15, bad: 1'b0};
    vecs[4] = '{len: 9'd0,   nodes: 7'd4,   tiles: 4'd0,  bad: 1'b1};
    vecs[5] = '{len: 9'd241, nodes: 7'd4,   tiles: 4'd0,  bad: 1'b1};
    vecs[6] = '{len: 9'd17,  nodes: 7'd0,   tiles: 4'd0,  bad: 1'b1};
    vecs[7] = '{len: 9'd33,  nodes: 7'd127, tiles: 4'd3,  bad: 1'b0};

    step();
    step();
    check("reset_outputs",
          32'({busy_o, done_o, err_o, wfetch_valid_o, feed_valid_o, wfetch_tile_o,
               feed_tile_o, tile_num_o}), 32'(0));
    check("reset_nodes", 32'({feed_len_o, out_node_num_o}), 32'(0));
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      run_layer(vecs[i].len, vecs[i].nodes, vecs[i].tiles, vecs[i].bad);
    end

    // Weight-fetch and feed backpressure on a single-tile layer.
    start_i = 1'b1; in_len_i = 9'd16; out_node_num_i = 7'd2; wfetch_ready_i = 1'b0;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_fetch_hold", 32'({wfetch_valid_o, feed_valid_o, wfetch_tile_o}), 32'(6'b100000));
      step();
    end
    wfetch_ready_i = 1'b1;
    feed_ready_i   = 1'b0;
    step();
    check("bp_advance", 32'({wfetch_valid_o, feed_valid_o}), 32'(2'b01));
    step();
    step();
    check("bp_feed_hold", 32'({feed_valid_o, feed_tile_o, feed_len_o}), 32'({1'b1, 4'd0, 7'd2}));
    feed_ready_i = 1'b1;
    step();
    check("bp_feed_drop", 32'(feed_valid_o), 32'(0));
    pvalid_i = 1'b1; step(); step(); pvalid_i = 1'b0;
    acc_last_i = 1'b1; step(); acc_last_i = 1'b0;
    check("bp_done", 32'({done_o, err_o}), 32'(2'b10));
    step();

    // Final beat of each tile coincides with the feed handshake.
    start_i = 1'b1; in_len_i = 9'd32; out_node_num_i = 7'd1;
    step();
    start_i = 1'b0;
    step();
    pvalid_i = 1'b1;
    step();
    pvalid_i = 1'b0;
    check("coinc_next_fetch", 32'({wfetch_valid_o, wfetch_tile_o, feed_valid_o}), 32'({1'b1, 4'd1, 1'b0}));
    step();
    pvalid_i = 1'b1;
    step();
    pvalid_i = 1'b0;
    check("coinc_wait_last", 32'({wfetch_valid_o, feed_valid_o, busy_o, err_o}), 32'(4'b0010));
    acc_last_i = 1'b1; step(); acc_last_i = 1'b0;
    check("coinc_done", 32'(done_o), 32'(1));
    step();

    // Stray beats and stray last in IDLE are sticky errors cleared by the next good start.
    pvalid_i = 1'b1; step(); pvalid_i = 1'b0;
    check("stray_pvalid", 32'({err_o, busy_o}), 32'(2'b10));
    run_layer(9'd16, 7'd4, 4'd1, 1'b0);
    acc_last_i = 1'b1; step(); acc_last_i = 1'b0;
    check("stray_acc_last", 32'({err_o, done_o}), 32'(2'b10));
    run_layer(9'd20, 7'd3, 4'd2, 1'b0);

    // Asynchronous reset in the middle of a drain.
    start_i = 1'b1; in_len_i = 9'd40; out_node_num_i = 7'd10;
    step();
    start_i = 1'b0;
    step();
    step();
    pvalid_i = 1'b1; step(); step(); step(); pvalid_i = 1'b0;
    check("pre_reset_busy", 32'({busy_o, wfetch_valid_o, feed_valid_o}), 32'(3'b100));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset",
          32'({busy_o, done_o, err_o, wfetch_valid_o, feed_valid_o, wfetch_tile_o,
               feed_tile_o, tile_num_o}), 32'(0));
    check("async_reset_nodes", 32'({feed_len_o, out_node_num_o}), 32'(0));
    step();
    rst_n = 1'b1;
    step();
    run_layer(9'd16, 7'd4, 4'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_layer_sequencer.md
# fc_layer_sequencer

Sequences one fully-connected layer through the systolic array and its per-column FC accumulators. It accepts a layer descriptor, derives the tile count, and issues one weight-fetch command and one input-feed command per tile. It counts the partial-sum beats coming off the array and holds the accumulator configuration stable for the whole layer. After the accumulator reports its last output, it signals completion. It sits between the top-level layer controller and the weight buffer, input feeder and FC accumulator.

## Interface
- `ARRAY_DIM`, 16: systolic rows, i.e. input features per tile. Must be a power of two.
- `MAX_TILES`, 15: maximum tiles per layer. Must fit the 4-bit tile field.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_i` in 1: layer start request.
- `in_len_i` in 9: input feature count, 1..ARRAY_DIM*MAX_TILES.
- `out_node_num_i` in 7: output node count, 1..127.
- `busy_o` out 1: layer in progress.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: sticky protocol/config error; cleared by the next accepted start.
- `wfetch_valid_o` out 1: weight-fetch command valid.
- `wfetch_ready_i` in 1: weight buffer accepts the command.
- `wfetch_tile_o` out 4: tile index of the fetch.
- `feed_valid_o` out 1: input-feed command valid.
- `feed_ready_i` in 1: feeder accepts the command.
- `feed_tile_o` out 4: tile index of the feed.
- `feed_len_o` out 7: vectors to stream, equal to out_node_num.
- `pvalid_i` in 1: array last-row psum valid, tapped in parallel with the accumulator.
- `acc_last_i` in 1: accumulator's final output beat.
- `out_node_num_o` out 7: accumulator output-node count.
- `tile_num_o` out 4: accumulator tile count.

## Operation
- **States:** IDLE, LOAD_W, FEED, DRAIN, WAIT_LAST, DONE.
- **IDLE:**
  - `start_i`=1 registers the descriptor and clears `err_o`.
  - Computes tiles = (in_len + ARRAY_DIM-1) >> log2(ARRAY_DIM).
  - Sets tile=0 and goes to LOAD_W.
  - If in_len=0, out_node_num=0, or tiles>MAX_TILES: set `err_o`, stay in IDLE, issue nothing.
- **LOAD_W:**
  - `wfetch_valid_o`=1 with `wfetch_tile_o`=tile.
  - On `wfetch_ready_i`, go to FEED.
- **FEED:**
  - `feed_valid_o`=1 with `feed_tile_o`=tile and `feed_len_o`=out_node_num.
  - On `feed_ready_i`, go to DRAIN.
- **DRAIN:**
  - Counts `pvalid_i` beats, and also counts beats arriving during FEED of the same tile.
  - When beat count = out_node_num: clear the count.
    - If tile = tiles-1, go to WAIT_LAST.
    - Otherwise tile+1 and go to LOAD_W.
- **WAIT_LAST:** on `acc_last_i`, go to DONE.
- **DONE:** `done_o`=1 for one cycle, then IDLE.
- **Accumulator configuration:**
  - `out_node_num_o`/`tile_num_o` equal the registered descriptor from the cycle after start acceptance.
  - Both are held unchanged until the next accepted start.
- **Errors (set `err_o`, sequencing continues):**
  - `pvalid_i` in IDLE, LOAD_W, WAIT_LAST or DONE.
  - `acc_last_i` in any state other than WAIT_LAST.
- `start_i` while `busy_o`=1 is ignored and is not an error.

## Timing
- **Reset:** every output is 0, state is IDLE and all counters are 0. Reset asserted mid-layer aborts immediately; no command stays pending.
- **Registered outputs:** all outputs come from registers.
  - `busy_o` rises the cycle after start is accepted and falls in the cycle `done_o` pulses.
- **Latency:** start accepted at cycle N gives `wfetch_valid_o`=1 at N+1.
- **Handshakes:** valid/ready.
  - A transfer occurs in a cycle where both are 1.
  - Valid drops in the next cycle.
  - The payload is stable while valid=1 and ready=0.
  - Valid never depends combinationally on ready.
- **Back-to-back:** ready=1 on valid's first cycle advances LOAD_W→FEED in one cycle. Minimum per-tile overhead is 2 cycles plus beats.
- **Final beat:** if the final pvalid beat of a tile coincides with the FEED handshake, the tile completes directly to the next state, and the beat is counted.
- **Completion:** `acc_last_i` at cycle M gives `done_o`=1 at M+1.
- **Widths:**
  - Beat counter is 7 bits with a compare against out_node_num; no wrap is possible.
  - Tile counter is 4 bits.

## Structure
- `fc_seq_pkg` holds:
  - the state enum;
  - `ARRAY_DIM`/`MAX_TILES` defaults;
  - width constants: `NODE_W`=7, `TILE_W`=4, `LEN_W`=9.
- Sub-module `fc_beat_counter`: clearable counter with terminal-count compare, instantiated for the beat count.
- The tile counter stays inline.

## Test plan
- **Single tile:** in_len=16, nodes=4, ready tied 1.
  - One fetch, tile 0; one feed, len 4.
  - 4 pvalid, then `acc_last_i` → `done_o` one cycle later.
  - `tile_num_o`=1, `out_node_num_o`=4.
- **Three tiles:** in_len=40, nodes=10.
  - Fetch/feed tiles 0,1,2 in order, each only after 10 beats.
  - `tile_num_o`=3.
- **Backpressure:** `wfetch_ready_i` held 0 for 5 cycles.
  - Valid and `wfetch_tile_o` stay stable.
  - Advance occurs exactly 1 cycle after ready.
- **Bad config:** in_len=0, or in_len=241 → `err_o`=1, no commands, `busy_o`=0.
- **Protocol errors:**
  - Stray `pvalid_i` in IDLE → `err_o`=1.
  - The next valid start clears it and the layer runs normally.
- **Reset mid-DRAIN:** async `rst_n` low → all outputs 0 immediately, state IDLE; a fresh start then works.
